// File: rtl/sr_latch_ctrl.sv
// ---------------------------------------------------------------------------
// sr_latch_ctrl
//
// Shares one SR latch between N_REQ requesters. Requests are granted
// round-robin. Each operation drives one S or R pulse of PULSE_W cycles,
// then holds S=R=0 for GUARD_W cycles, then checks Q/Q_bar against the
// requested operation and acknowledges the requester with a pass/fail status.
// This block is the only driver of the latch's S and R pins.
//
// Parameters:
//   N_REQ   - number of requesters (>=1)
//   PULSE_W - cycles S or R is held high per operation (>=1)
//   GUARD_W - cycles with S=R=0 before Q is checked (>=1)
//
// Ports:
//   clk        in   clock, rising edge
//   rst_n      in   asynchronous active-low reset
//   req_valid  in   [N_REQ] request pending per requester, held until acked
//   req_op     in   [N_REQ] requested operation: 1=set, 0=reset
//   req_ack    out  [N_REQ] one-hot, one-cycle acknowledge
//   req_err    out  readback mismatch, coincident with req_ack
//   busy       out  high whenever the sequencer is not idle
//   fault      out  sticky readback error, cleared only by reset
//   S, R       out  latch set / reset drive
//   Q, Q_bar   in   latch outputs
//
// State table:
//   state | meaning
//   IDLE  | waiting for a request; grant is taken on the next edge
//   DRIVE | S (set) or R (reset) held high for PULSE_W cycles
//   GUARD | S=R=0 for GUARD_W cycles so the latch settles
//   CHECK | req_ack/req_err presented for one cycle
// ---------------------------------------------------------------------------
module sr_latch_ctrl #(
    parameter int N_REQ   = 2,
    parameter int PULSE_W = 2,
    parameter int GUARD_W = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N_REQ-1:0] req_valid,
    input  logic [N_REQ-1:0] req_op,
    output logic [N_REQ-1:0] req_ack,
    output logic             req_err,
    output logic             busy,
    output logic             fault,
    output logic             S,
    output logic             R,
    input  logic             Q,
    input  logic             Q_bar
);

    localparam int IDX_W   = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int CNT_MAX = (PULSE_W > GUARD_W) ? PULSE_W : GUARD_W;
    localparam int CNT_W   = $clog2(CNT_MAX) + 1;

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] DRIVE = 2'd1;
    localparam logic [1:0] GUARD = 2'd2;
    localparam logic [1:0] CHECK = 2'd3;

    logic [1:0]       state;
    logic [CNT_W-1:0] cnt;
    logic [IDX_W-1:0] idx;
    logic [IDX_W-1:0] rr_ptr;
    logic             op;

    logic [IDX_W-1:0] grant_idx;
    logic             grant_found;
    logic             mismatch;
    logic [N_REQ-1:0] ack_vec;

    // Round-robin pick: first valid requester strictly after rr_ptr.
    // The first pass covers indices above the pointer; if none is valid
    // there, the second pass wraps around and takes the lowest valid one.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (!grant_found && req_valid[i] && (i > int'(rr_ptr))) begin
                grant_found = 1'b1;
                grant_idx   = IDX_W'(i);
            end
        end
        for (int i = 0; i < N_REQ; i++) begin
            if (!grant_found && req_valid[i]) begin
                grant_found = 1'b1;
                grant_idx   = IDX_W'(i);
            end
        end
    end

    // Q==Q_bar (either polarity) never matches op and ~op together,
    // so it is reported as a mismatch.
    assign mismatch = (Q != op) | (Q_bar != ~op);
    assign ack_vec  = N_REQ'(1) << idx;

    // Outputs are registered from the next state, so S/R rise on the grant
    // edge and the readback is sampled on the edge that leaves GUARD.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            cnt     <= '0;
            idx     <= '0;
            rr_ptr  <= IDX_W'(N_REQ - 1);
            op      <= 1'b0;
            req_ack <= '0;
            req_err <= 1'b0;
            busy    <= 1'b0;
            fault   <= 1'b0;
            S       <= 1'b0;
            R       <= 1'b0;
        end else begin
            req_ack <= '0;
            req_err <= 1'b0;
            case (state)
                IDLE: begin
                    if (grant_found) begin
                        state  <= DRIVE;
                        cnt    <= CNT_W'(PULSE_W - 1);
                        idx    <= grant_idx;
                        rr_ptr <= grant_idx;
                        op     <= req_op[grant_idx];
                        S      <= req_op[grant_idx];
                        R      <= ~req_op[grant_idx];
                        busy   <= 1'b1;
                    end
                end
                DRIVE: begin
                    if (cnt == '0) begin
                        state <= GUARD;
                        cnt   <= CNT_W'(GUARD_W - 1);
                        S     <= 1'b0;
                        R     <= 1'b0;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                GUARD: begin
                    if (cnt == '0) begin
                        state   <= CHECK;
                        req_ack <= ack_vec;
                        req_err <= mismatch;
                        if (mismatch) begin
                            fault <= 1'b1;
                        end
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    S     <= 1'b0;
                    R     <= 1'b0;
                end
            endcase
        end
    end

endmodule
